// File: rtl/string_pkg.sv
// Shared types and constants for the WS2812B string frame sequencer.
// Optional brightness scaling is enabled with STRING_SEQ_BRIGHTNESS_EN.
package string_pkg;

    localparam int PIXEL_W              = 24;
    localparam int CHAN_W               = 8;
    localparam int DEFAULT_GUARD_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        RD_WAIT,
        SCALE,
        PRESENT,
        BLANK_REQ,
        BLANK_WAIT
    } seq_state_t;

endpackage

// File: rtl/string_pixel_scale.sv
// Combinational per-channel brightness scaling of a GRB pixel; full scale (255) passes through.
// Only instantiated when STRING_SEQ_BRIGHTNESS_EN is defined.
module string_pixel_scale
    import string_pkg::*;
(
    input  logic [PIXEL_W-1:0] pixel_in,
    input  logic [CHAN_W-1:0]  brightness,
    output logic [PIXEL_W-1:0] pixel_out
);

    for (genvar c = 0; c < PIXEL_W / CHAN_W; c++) begin : g_chan
        logic [2*CHAN_W-1:0] product;

        assign product = {{CHAN_W{1'b0}}, pixel_in[c*CHAN_W +: CHAN_W]}
                       * {{CHAN_W{1'b0}}, brightness};

        assign pixel_out[c*CHAN_W +: CHAN_W] = (brightness == '1)
                                             ? pixel_in[c*CHAN_W +: CHAN_W]
                                             : product[2*CHAN_W-1:CHAN_W];
    end

endmodule

// File: rtl/string_frame_sequencer.sv
// Frame-level controller feeding one WS2812B string driver from a synchronous pixel RAM.
// Define STRING_SEQ_BRIGHTNESS_EN to add the brightness input and the SCALE pipeline state.
module string_frame_sequencer
    import string_pkg::*;
#(
    parameter int                ADDR_W       = 9,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int                GUARD_CYCLES = DEFAULT_GUARD_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic [ADDR_W-1:0]   num_leds,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [PIXEL_W-1:0]  mem_rd_data,
`ifdef STRING_SEQ_BRIGHTNESS_EN
    input  logic [CHAN_W-1:0]   brightness,
`endif
    output logic [PIXEL_W-1:0]  pixel_data,
    output logic                pixel_data_valid,
    output logic                h_blank,
    input  logic                string_ready,
    output logic                busy,
    output logic                frame_done
);

    localparam int                 GUARD_W    = $clog2(GUARD_CYCLES + 1);
    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES);
    localparam logic [GUARD_W-1:0] GUARD_ONE  = GUARD_W'(1);
    localparam logic [ADDR_W-1:0]  IDX_ONE    = ADDR_W'(1);

    seq_state_t          state;
    seq_state_t          state_next;
    logic [ADDR_W-1:0]   n_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [GUARD_W-1:0]  guard_q;
    logic                ready_eff;
    logic                strobe;

    // The driver's ready is stale for a few cycles after each strobe, so it is masked by the guard.
    assign ready_eff = string_ready && (guard_q == '0);
    assign strobe    = pixel_data_valid || h_blank;

`ifdef STRING_SEQ_BRIGHTNESS_EN
    logic [PIXEL_W-1:0] raw_q;
    logic [PIXEL_W-1:0] scaled;

    string_pixel_scale u_scale (
        .pixel_in   (raw_q),
        .brightness (brightness),
        .pixel_out  (scaled)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            n_q        <= '0;
            idx_q      <= '0;
            guard_q    <= '0;
            pixel_data <= '0;
`ifdef STRING_SEQ_BRIGHTNESS_EN
            raw_q      <= '0;
`endif
        end else begin
            state <= state_next;

            if (strobe) begin
                guard_q <= GUARD_LOAD;
            end else if (guard_q != '0) begin
                guard_q <= guard_q - GUARD_ONE;
            end

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        n_q   <= num_leds;
                        idx_q <= '0;
                    end
                end
`ifdef STRING_SEQ_BRIGHTNESS_EN
                RD_WAIT: raw_q      <= mem_rd_data;
                SCALE:   pixel_data <= scaled;
`else
                RD_WAIT: pixel_data <= mem_rd_data;
`endif
                PRESENT: begin
                    if (ready_eff) begin
                        idx_q <= idx_q + IDX_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes are combinational from the state so a reset silences them on the very next cycle.
    always_comb begin
        state_next       = state;
        mem_rd_en        = 1'b0;
        mem_addr         = '0;
        pixel_data_valid = 1'b0;
        h_blank          = 1'b0;
        frame_done       = 1'b0;
        busy             = (state != IDLE);

        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_next = (num_leds == '0) ? BLANK_REQ : FETCH;
                end
            end
            FETCH: begin
                mem_rd_en  = 1'b1;
                mem_addr   = BASE_ADDR + idx_q;
                state_next = RD_WAIT;
            end
`ifdef STRING_SEQ_BRIGHTNESS_EN
            RD_WAIT: state_next = SCALE;
            SCALE:   state_next = PRESENT;
`else
            RD_WAIT: state_next = PRESENT;
`endif
            PRESENT: begin
                if (ready_eff) begin
                    pixel_data_valid = 1'b1;
                    state_next       = ((idx_q + IDX_ONE) == n_q) ? BLANK_REQ : FETCH;
                end
            end
            BLANK_REQ: begin
                if (ready_eff) begin
                    h_blank    = 1'b1;
                    state_next = BLANK_WAIT;
                end
            end
            BLANK_WAIT: begin
                if (ready_eff) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_string_frame_sequencer.sv
// Self-checking bench for string_frame_sequencer with a WS2812B driver model and a pixel RAM model.
// Builds with or without STRING_SEQ_BRIGHTNESS_EN.
module tb_string_frame_sequencer;
    import string_pkg::*;

    localparam int ADDR_W = 9;
    localparam int GUARD  = DEFAULT_GUARD_CYCLES;
`ifdef STRING_SEQ_BRIGHTNESS_EN
    localparam int XL = 1;
`else
    localparam int XL = 0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               frame_start = 1'b0;
    logic [ADDR_W-1:0]  num_leds = '0;
    logic               mem_rd_en;
    logic [ADDR_W-1:0]  mem_addr;
    logic [23:0]        mem_rd_data = '0;
    logic [23:0]        pixel_data;
    logic               pixel_data_valid;
    logic               h_blank;
    logic               string_ready;
    logic               busy;
    logic               frame_done;
`ifdef STRING_SEQ_BRIGHTNESS_EN
    logic [7:0]         brightness = 8'd255;
`endif
    int                 bright = 255;

    string_frame_sequencer #(
        .ADDR_W       (ADDR_W),
        .GUARD_CYCLES (GUARD)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .frame_start      (frame_start),
        .num_leds         (num_leds),
        .mem_rd_en        (mem_rd_en),
        .mem_addr         (mem_addr),
        .mem_rd_data      (mem_rd_data),
`ifdef STRING_SEQ_BRIGHTNESS_EN
        .brightness       (brightness),
`endif
        .pixel_data       (pixel_data),
        .pixel_data_valid (pixel_data_valid),
        .h_blank          (h_blank),
        .string_ready     (string_ready),
        .busy             (busy),
        .frame_done       (frame_done)
    );

    // 100-unit clock period
    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] ram [0:511];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

    // Driver model: busy for pix_cycles per pixel or blank_cycles per blank, ready lags by one register.
    int   pix_cycles = 300;
    int   blank_cycles = 500;
    int   drv_cnt = 0;
    int   drv_violations = 0;
    logic drv_ready_q = 1'b1;
    logic force_ready = 1'b0;
    assign string_ready = force_ready | drv_ready_q;

    always @(posedge clk) begin
        if (!force_ready && (pixel_data_valid || h_blank) && drv_cnt != 0)
            drv_violations <= drv_violations + 1;
        if (pixel_data_valid)      drv_cnt <= pix_cycles;
        else if (h_blank)          drv_cnt <= blank_cycles;
        else if (drv_cnt != 0)     drv_cnt <= drv_cnt - 1;
        drv_ready_q <= (drv_cnt == 0);
    end

    logic [23:0] px_q[$];
    int vcyc_q[$];
    int bcyc_q[$];
    int dcyc_q[$];
    int rd_total = 0;
    int overlap_err = 0;
    int gap_err = 0;
    int busy_err = 0;
    int last_strobe = -100;
    bit in_frame = 1'b0;

    always @(negedge clk) begin
        if (pixel_data_valid && h_blank) overlap_err++;
        if (pixel_data_valid || h_blank) begin
            if (cyc - last_strobe <= GUARD) gap_err++;
            last_strobe = cyc;
        end
        if (pixel_data_valid) begin
            px_q.push_back(pixel_data);
            vcyc_q.push_back(cyc);
        end
        if (h_blank)    bcyc_q.push_back(cyc);
        if (frame_done) dcyc_q.push_back(cyc);
        if (mem_rd_en)  rd_total++;
        if (in_frame && !busy) busy_err++;
    end

    int checks = 0;
    int failures = 0;
    int start_cyc, v0, b0, r0, d0;

    typedef struct {
        int n;
        bit forced;
        int pix;
        int blank;
        int exp_valids;
        int exp_lat;
        int exp_done;
    } vec_t;
    vec_t vecs[5];

    function automatic logic [23:0] ref_pixel(input logic [23:0] raw, input int b);
        int res = 0;
        if (b == 255) return raw;
        for (int c = 0; c < 3; c++) begin
            int ch = (int'(raw) >> (8 * c)) & 255;
            res = res | (((ch * b) / 256) << (8 * c));
        end
        return 24'(res);
    endfunction

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic wait_driver_idle();
        int k = 0;
        while (!(drv_cnt == 0 && drv_ready_q) && k < 5000) begin
            @(posedge clk); #1; k++;
        end
        check_output("driver_idle_wait", int'(k < 5000), 1);
    endtask

    task automatic apply_stimulus(input int n);
        @(posedge clk); #1;
        num_leds    = ADDR_W'(n);
        frame_start = 1'b1;
        start_cyc   = cyc;
        v0 = px_q.size(); b0 = bcyc_q.size(); r0 = rd_total; d0 = dcyc_q.size();
        @(posedge clk); #1;
        frame_start = 1'b0;
        in_frame    = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (dcyc_q.size() == d0 && k < budget) begin
            @(posedge clk); #1; k++;
        end
        check_output($sformatf("%s_done_timeout", tag), int'(dcyc_q.size() > d0), 1);
        in_frame = 1'b0;
    endtask

    task automatic wait_pixels(input string tag, input int count);
        int k = 0;
        while (px_q.size() < v0 + count && k < 5000) begin
            @(posedge clk); #1; k++;
        end
        check_output($sformatf("%s_pixel_timeout", tag), int'(px_q.size() >= v0 + count), 1);
    endtask

    task automatic verify_frame(input string tag, input int n, input int exp_lat, input int exp_done);
        int got = px_q.size() - v0;
        check_output($sformatf("%s_valids", tag), got, n);
        for (int k = 0; k < n && k < got; k++)
            check_output($sformatf("%s_px%0d", tag, k), px_q[v0 + k], ref_pixel(ram[k], bright));
        check_output($sformatf("%s_blanks", tag), bcyc_q.size() - b0, 1);
        check_output($sformatf("%s_reads", tag), rd_total - r0, n);
        check_output($sformatf("%s_dones", tag), dcyc_q.size() - d0, 1);
        if (exp_lat >= 0 && got > 0)
            check_output($sformatf("%s_latency", tag), vcyc_q[v0] - start_cyc, exp_lat);
        if (exp_done >= 0 && dcyc_q.size() > d0)
            check_output($sformatf("%s_done_cycle", tag), dcyc_q[d0] - start_cyc, exp_done);
    endtask

    task automatic run_vector(input string tag, input vec_t v);
        force_ready = 1'b0;
        wait_driver_idle();
        force_ready  = v.forced;
        pix_cycles   = v.pix;
        blank_cycles = v.blank;
        apply_stimulus(v.n);
        wait_done(tag, 20000);
        verify_frame(tag, v.exp_valids, v.exp_lat, v.exp_done);
        if (v.n == 0 && bcyc_q.size() > b0 && dcyc_q.size() > d0) begin
            check_output({tag, "_blank_soon"}, int'(bcyc_q[b0] - start_cyc <= 2), 1);
            check_output({tag, "_done_after_blank"}, int'(dcyc_q[d0] - bcyc_q[b0] >= v.blank), 1);
        end
    endtask

    initial begin
        #(100 * 80000);
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 24'($urandom);
        ram[0] = 24'hFF0000;
        ram[1] = 24'h00FF00;
        ram[2] = 24'h0000FF;

        vecs[0] = '{n: 3, forced: 1'b0, pix: 300, blank: 500, exp_valids: 3, exp_lat: 3 + XL, exp_done: -1};
        vecs[1] = '{n: 0, forced: 1'b0, pix: 300, blank: 500, exp_valids: 0, exp_lat: -1,     exp_done: -1};
        vecs[2] = '{n: 4, forced: 1'b1, pix: 300, blank: 500, exp_valids: 4, exp_lat: 3 + XL, exp_done: 18 + 4 * XL};
        vecs[3] = '{n: 1, forced: 1'b1, pix: 300, blank: 500, exp_valids: 1, exp_lat: 3 + XL, exp_done: 9 + XL};
        vecs[4] = '{n: 2, forced: 1'b0, pix: 20,  blank: 30,  exp_valids: 2, exp_lat: 3 + XL, exp_done: -1};

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_outputs",
                     {mem_rd_en, mem_addr, pixel_data, pixel_data_valid, h_blank, busy, frame_done}, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vector($sformatf("vec%0d", i), vecs[i]);

        // Restart request and num_leds change in the middle of a 5-pixel frame must be ignored.
        force_ready = 1'b0;
        wait_driver_idle();
        pix_cycles = 40; blank_cycles = 60;
        apply_stimulus(5);
        wait_pixels("midstart", 2);
        num_leds = ADDR_W'(7); frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        wait_done("midstart", 5000);
        verify_frame("midstart", 5, 3 + XL, -1);
        repeat (30) @(posedge clk);
        #1;
        check_output("midstart_single_done", dcyc_q.size() - d0, 1);
        check_output("midstart_idle_after", busy, 0);

        // A request coinciding with frame_done is dropped.
        wait_driver_idle();
        force_ready = 1'b1;
        apply_stimulus(2);
        for (int k = 0; k < 200 && !frame_done; k++) begin
            @(posedge clk); #1;
        end
        check_output("done_cycle_seen", frame_done, 1);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        in_frame    = 1'b0;
        check_output("start_at_done_dropped", busy, 0);
        repeat (5) @(posedge clk);
        #1;
        check_output("start_at_done_no_reads", rd_total - r0, 2);

        // Reset while the second of three pixels is in flight; the driver keeps running on its own.
        force_ready = 1'b0;
        wait_driver_idle();
        pix_cycles = 300; blank_cycles = 500;
        apply_stimulus(3);
        wait_pixels("rst", 2);
        in_frame = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_output("rst_outputs",
                     {mem_rd_en, mem_addr, pixel_data, pixel_data_valid, h_blank, busy, frame_done}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        apply_stimulus(1);
        wait_done("rst_next", 5000);
        verify_frame("rst_next", 1, -1, -1);
        if (px_q.size() > v0)
            check_output("rst_waits_ready", int'(vcyc_q[v0] - start_cyc > 10), 1);

`ifdef STRING_SEQ_BRIGHTNESS_EN
        wait_driver_idle();
        force_ready = 1'b1;
        ram[0] = 24'hFF8040;
        brightness = 8'd128; bright = 128;
        apply_stimulus(1);
        wait_done("bright128", 200);
        if (px_q.size() > v0) check_output("bright128_px", px_q[v0], 24'h7F4020);
        brightness = 8'd255; bright = 255;
        apply_stimulus(1);
        wait_done("bright255", 200);
        if (px_q.size() > v0) check_output("bright255_px", px_q[v0], 24'hFF8040);
`endif

        // Random frames against the RAM-contents model with random driver timing.
        for (int f = 0; f < 6; f++) begin
            vec_t v;
            for (int i = 0; i < 16; i++) ram[i] = 24'($urandom);
`ifdef STRING_SEQ_BRIGHTNESS_EN
            bright = int'($urandom_range(0, 255));
            brightness = 8'(bright);
`endif
            v.n          = int'($urandom_range(1, 8));
            v.forced     = 1'($urandom_range(0, 1));
            v.pix        = int'($urandom_range(3, 40));
            v.blank      = int'($urandom_range(5, 60));
            v.exp_valids = v.n;
            v.exp_lat    = 3 + XL;
            v.exp_done   = -1;
            run_vector($sformatf("rand%0d", f), v);
        end

        repeat (5) @(posedge clk);
        check_output("strobe_overlap", overlap_err, 0);
        check_output("strobe_gap", gap_err, 0);
        check_output("busy_gap", busy_err, 0);
        check_output("driver_protocol", drv_violations, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/string_frame_sequencer.md
Name: string_frame_sequencer

Overview:
- Frame-level controller for one WS2812B string driver.
- On a frame request, reads pixels 0..num_leds-1 from a synchronous pixel RAM and hands each one to the string driver through its pixel_data/pixel_data_valid/string_ready handshake.
- After the last pixel it issues the blank/reset pulse (h_blank), waits for the driver to finish, then reports frame completion.
- Sits between the frame buffer and the string driver: one instance per string.

Parameters:
- ADDR_W, 9, pixel RAM address width; max string length 2^ADDR_W - 1.
- BASE_ADDR, 0, RAM address of pixel 0; width ADDR_W.
- GUARD_CYCLES, 2, cycles string_ready is ignored after each valid or h_blank pulse, covering the driver's ready-deassert latency; minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle request to send a frame; ignored while busy
- num_leds  in  ADDR_W  pixel count; sampled when a frame_start is accepted
- mem_rd_en  out  1  RAM read strobe; data valid exactly 1 cycle later
- mem_addr  out  ADDR_W  RAM read address
- mem_rd_data  in  24  RAM read data, GRB, MSB first
- pixel_data  out  24  pixel to driver
- pixel_data_valid  out  1  one-cycle load strobe to driver
- h_blank  out  1  one-cycle blank request to driver
- string_ready  in  1  driver ready (shift and blank idle)
- busy  out  1  high from frame_start acceptance until frame_done
- frame_done  out  1  one-cycle pulse when the blank completes

Behaviour:
- Reset values: all outputs 0; pixel_data 0; state IDLE; pixel counter 0; guard counter 0.
- The driver has no reset. After rst, the first strobe of any kind waits for string_ready=1.
- State IDLE:
  - frame_start=1 -> latch num_leds to n, clear index i, assert busy.
  - If n=0, go to BLANK_REQ; otherwise go to FETCH.
- State FETCH: mem_rd_en=1 for one cycle, mem_addr=BASE_ADDR+i with modulo-2^ADDR_W wrap -> RD_WAIT.
- State RD_WAIT: capture mem_rd_data into pixel_data -> PRESENT.
- State PRESENT:
  - Wait for string_ready=1 and guard counter=0.
  - Then pulse pixel_data_valid for 1 cycle, load guard=GUARD_CYCLES, i<=i+1.
  - If i+1==n go to BLANK_REQ, else go to FETCH.
  - The prefetch for pixel i+1 overlaps the guard window and the driver's bit time.
- State BLANK_REQ: wait for string_ready=1 and guard=0. Then pulse h_blank for 1 cycle, load guard -> BLANK_WAIT.
- State BLANK_WAIT: wait for guard=0 and string_ready=1. Then pulse frame_done, deassert busy -> IDLE.
- Guard counter: decrements to 0 each cycle; string_ready is treated as 0 while the counter is nonzero.
- Strobe exclusivity: pixel_data_valid and h_blank are never both high, and never within GUARD_CYCLES of each other or of themselves.
- pixel_data stays stable from RD_WAIT until the next RD_WAIT.
- Latency: frame_start to first pixel_data_valid is 3 cycles when string_ready=1.
- frame_start while busy: dropped, with no queueing and no effect on n.
- frame_start in the same cycle as frame_done: dropped; the next cycle in IDLE accepts.
- num_leds changing mid-frame: no effect.
- rst mid-frame: immediate return to IDLE and all strobes low. The driver finishes its current bit or blank on its own; the next frame waits for string_ready.

Optional Feature:
- Macro: STRING_SEQ_BRIGHTNESS_EN.
- Defined:
  - Adds input port brightness [7:0].
  - In RD_WAIT, each 8-bit channel becomes (ch*brightness)>>8, except brightness=255, which passes the channel unmodified.
  - The result is registered in an extra SCALE state between RD_WAIT and PRESENT.
  - Start-to-first-valid latency becomes 4 cycles.
  - brightness is sampled per pixel.
- Undefined: no brightness port, no SCALE state, data passes unmodified.

Decomposition:
- Shared package string_pkg:
  - State encoding: IDLE, FETCH, RD_WAIT, SCALE, PRESENT, BLANK_REQ, BLANK_WAIT.
  - Pixel width constant 24 and channel width 8.
  - Default GUARD_CYCLES.
- Sub-module string_pixel_scale: combinational 3-channel brightness multiply, instantiated only under the macro.
- All other logic is in one module.

Test Plan:
- Driver model with realistic timing at CLK_PERIOD_NS=100, num_leds=3, RAM holds 0xFF0000/0x00FF00/0x0000FF, frame_start -> exactly 3 valid pulses carrying those values in order, then 1 h_blank, then frame_done; busy high throughout.
- num_leds=0, frame_start -> no mem_rd_en, no pixel_data_valid; h_blank within 2 cycles; frame_done after the driver's blank completes (about 500 cycles).
- string_ready forced to 1 permanently, num_leds=4 -> consecutive valid pulses are at least GUARD_CYCLES+1 cycles apart; no strobe overlap.
- frame_start pulsed again mid-frame, with num_leds changed to 7 during a 5-LED frame -> still exactly 5 pixels and a single frame_done.
- rst asserted while the 2nd of 3 pixels is in flight -> next cycle all outputs 0, state IDLE. A new frame_start issues its first valid only after string_ready returns to 1.
- With STRING_SEQ_BRIGHTNESS_EN, brightness=128, pixel 0xFF8040 -> pixel_data=0x7F4020; brightness=255 -> 0xFF8040 unchanged.
